// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register-file write port between writeback (fixed priority) and a buffered aux producer.
// Optional RF_ARB_STATS_EN adds saturating stat_aux_writes / stat_stall_cycles counters.
module rf_write_arbiter #(
  parameter int DEPTH = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wb_we,
  input  logic [4:0]               wb_addr,
  input  logic [31:0]              wb_data,
  input  logic                     aux_valid,
  output logic                     aux_ready,
  input  logic [4:0]               aux_addr,
  input  logic [31:0]              aux_data,
  output logic                     rf_we,
  output logic [4:0]               rf_waddr,
  output logic [31:0]              rf_wdata,
  output logic                     wb_stall,
  output logic [31:0]              busy_mask,
`ifdef RF_ARB_STATS_EN
  output logic [15:0]              stat_aux_writes,
  output logic [15:0]              stat_stall_cycles,
`endif
  output logic [$clog2(DEPTH):0]   fifo_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int AW = $clog2(STARVE_LIMIT + 1);
  logic [4:0] addr_q [DEPTH];
  logic [4:0] addr_d [DEPTH];
  logic [31:0] data_q [DEPTH];
  logic [31:0] data_d [DEPTH];
  logic [DEPTH-1:0] live_q, live_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] age_q, age_d;
  logic rf_we_q, rf_we_d, rf_aux_q, rf_aux_d, wb_stall_q, wb_stall_d;
  logic [4:0] rf_waddr_q, rf_waddr_d;
  logic [31:0] rf_wdata_q, rf_wdata_d;
  logic wb_hit, push, pop, head_live, aux_issue;
  assign aux_ready = count_q != CW'(DEPTH);
  always_comb begin
    wb_hit = wb_we && wb_addr != 5'd0;
    push = aux_valid && aux_ready && aux_addr != 5'd0;
    pop = !wb_hit && count_q != '0;
    head_live = live_q[rd_ptr_q];
    aux_issue = pop && head_live;
    addr_d = addr_q;
    data_d = data_q;
    live_d = live_q;
    // a writeback is younger than every queued aux write, so it supersedes them
    for (int i = 0; i < DEPTH; i++)
      if (wb_hit && addr_q[i] == wb_addr) live_d[i] = 1'b0;
    if (pop) live_d[rd_ptr_q] = 1'b0;
    if (push) begin
      addr_d[wr_ptr_q] = aux_addr;
      data_d[wr_ptr_q] = aux_data;
      live_d[wr_ptr_q] = !(wb_hit && aux_addr == wb_addr);
    end
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d = count_q + CW'(push) - CW'(pop);
    rf_we_d = wb_hit || aux_issue;
    rf_aux_d = aux_issue;
    rf_waddr_d = wb_hit ? wb_addr : aux_issue ? addr_q[rd_ptr_q] : rf_waddr_q;
    rf_wdata_d = wb_hit ? wb_data : aux_issue ? data_q[rd_ptr_q] : rf_wdata_q;
    // while non-empty and not popping, the head is necessarily blocked by writeback
    age_d = (pop || count_q == '0) ? '0 : (age_q == AW'(STARVE_LIMIT)) ? age_q : age_q + 1'b1;
    wb_stall_d = age_q == AW'(STARVE_LIMIT) && !pop;
  end
  always_comb begin
    busy_mask = rf_aux_q ? (32'd1 << rf_waddr_q) : 32'd0;
    for (int i = 0; i < DEPTH; i++)
      if (live_q[i]) busy_mask[addr_q[i]] = 1'b1;
  end
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      live_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      age_q <= '0;
      rf_we_q <= 1'b0;
      rf_aux_q <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      wb_stall_q <= 1'b0;
    end else begin
      live_q <= live_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      age_q <= age_d;
      rf_we_q <= rf_we_d;
      rf_aux_q <= rf_aux_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      wb_stall_q <= wb_stall_d;
    end
  end
  assign rf_we = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign wb_stall = wb_stall_q;
  assign fifo_count = count_q;
`ifdef RF_ARB_STATS_EN
  logic [15:0] stat_aw_q, stat_aw_d, stat_sc_q, stat_sc_d;
  always_comb begin
    stat_aw_d = (aux_issue && stat_aw_q != 16'hFFFF) ? stat_aw_q + 16'd1 : stat_aw_q;
    stat_sc_d = (wb_stall_q && stat_sc_q != 16'hFFFF) ? stat_sc_q + 16'd1 : stat_sc_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_aw_q <= '0;
      stat_sc_q <= '0;
    end else begin
      stat_aw_q <= stat_aw_d;
      stat_sc_q <= stat_sc_d;
    end
  end
  assign stat_aux_writes = stat_aw_q;
  assign stat_stall_cycles = stat_sc_q;
`endif
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: table-driven directed checks of rf_write_arbiter plus starvation and reset sequences.
module tb_rf_write_arbiter;
  logic clk = 0, reset = 1;
  logic wb_we = 0, aux_valid = 0;
  logic [4:0] wb_addr = 0, aux_addr = 0;
  logic [31:0] wb_data = 0, aux_data = 0;
  logic aux_ready, rf_we, wb_stall;
  logic [4:0] rf_waddr;
  logic [31:0] rf_wdata, busy_mask;
  logic [2:0] fifo_count;
  int checks = 0, fails = 0;
`ifdef RF_ARB_STATS_EN
  logic [15:0] stat_aux_writes, stat_stall_cycles;
`endif
  rf_write_arbiter dut (
    .clk(clk), .reset(reset), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_addr(aux_addr), .aux_data(aux_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .wb_stall(wb_stall),
    .busy_mask(busy_mask),
`ifdef RF_ARB_STATS_EN
    .stat_aux_writes(stat_aux_writes), .stat_stall_cycles(stat_stall_cycles),
`endif
    .fifo_count(fifo_count));
  always #5 clk = ~clk;
  typedef struct {
    logic wwe; logic [4:0] wa; logic [31:0] wd;
    logic av; logic [4:0] aa; logic [31:0] ad;
    logic e_we; logic [4:0] e_addr; logic [31:0] e_data;
    logic [2:0] e_cnt; logic [31:0] e_busy; logic e_rdy;
  } vec_t;
  vec_t v [16];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int n;
    v[0]  = '{1'b1, 5'd5,  32'h1234, 1'b0, 5'd0,  32'h0,   1'b1, 5'd5,  32'h1234, 3'd0, 32'h0, 1'b1};
    v[1]  = '{1'b0, 5'd0,  32'h0,    1'b1, 5'd7,  32'h400, 1'b0, 5'd5,  32'h1234, 3'd1, 32'h80, 1'b1};
    v[2]  = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,   1'b1, 5'd7,  32'h400,  3'd0, 32'h80, 1'b1};
    v[3]  = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,   1'b0, 5'd7,  32'h400,  3'd0, 32'h0, 1'b1};
    v[4]  = '{1'b1, 5'd3,  32'h33,   1'b1, 5'd9,  32'h99,  1'b1, 5'd3,  32'h33,   3'd1, 32'h200, 1'b1};
    v[5]  = '{1'b1, 5'd9,  32'hAA,   1'b0, 5'd0,  32'h0,   1'b1, 5'd9,  32'hAA,   3'd1, 32'h0, 1'b1};
    v[6]  = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,   1'b0, 5'd9,  32'hAA,   3'd0, 32'h0, 1'b1};
    v[7]  = '{1'b1, 5'd12, 32'hC,    1'b1, 5'd12, 32'h5,   1'b1, 5'd12, 32'hC,    3'd1, 32'h0, 1'b1};
    v[8]  = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,   1'b0, 5'd12, 32'hC,    3'd0, 32'h0, 1'b1};
    v[9]  = '{1'b1, 5'd0,  32'hFF,   1'b1, 5'd0,  32'h77,  1'b0, 5'd12, 32'hC,    3'd0, 32'h0, 1'b1};
    v[10] = '{1'b0, 5'd0,  32'h0,    1'b1, 5'd15, 32'hF5,  1'b0, 5'd12, 32'hC,    3'd1, 32'h8000, 1'b1};
    v[11] = '{1'b1, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,   1'b1, 5'd15, 32'hF5,   3'd0, 32'h8000, 1'b1};
    v[12] = '{1'b0, 5'd0,  32'h0,    1'b1, 5'd20, 32'h20,  1'b0, 5'd15, 32'hF5,   3'd1, 32'h100000, 1'b1};
    v[13] = '{1'b0, 5'd0,  32'h0,    1'b1, 5'd21, 32'h21,  1'b1, 5'd20, 32'h20,   3'd1, 32'h300000, 1'b1};
    v[14] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,   1'b1, 5'd21, 32'h21,   3'd0, 32'h200000, 1'b1};
    v[15] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,   1'b0, 5'd21, 32'h21,   3'd0, 32'h0, 1'b1};
    step();
    step();
    chk("rst_rf_we", rf_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_stall", wb_stall, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_busy", busy_mask, 0);
    reset = 0;
    for (int i = 0; i < 16; i++) begin
      wb_we = v[i].wwe; wb_addr = v[i].wa; wb_data = v[i].wd;
      aux_valid = v[i].av; aux_addr = v[i].aa; aux_data = v[i].ad;
      step();
      chk($sformatf("v%0d_rf_we", i), rf_we, v[i].e_we);
      chk($sformatf("v%0d_waddr", i), rf_waddr, v[i].e_addr);
      chk($sformatf("v%0d_wdata", i), rf_wdata, v[i].e_data);
      chk($sformatf("v%0d_count", i), fifo_count, v[i].e_cnt);
      chk($sformatf("v%0d_busy", i), busy_mask, v[i].e_busy);
      chk($sformatf("v%0d_ready", i), aux_ready, v[i].e_rdy);
    end
    wb_we = 1; wb_addr = 1; wb_data = 32'h111;
    for (int k = 0; k < 4; k++) begin
      aux_valid = 1; aux_addr = (k == 3) ? 5'd6 : 5'(k + 2); aux_data = 32'hA0 + k;
      step();
    end
    aux_valid = 0;
    chk("full_count", fifo_count, 4);
    chk("full_ready", aux_ready, 0);
    chk("full_busy", busy_mask, 32'h5C);
    chk("full_nostall", wb_stall, 0);
    n = 0;
    while (!wb_stall && n < 20) begin
      step();
      n++;
    end
    chk("stall_latency", n, 6);
    step();
    chk("stall_hold", wb_stall, 1);
    chk("stall_wb_wins_we", rf_we, 1);
    chk("stall_wb_wins_addr", rf_waddr, 1);
    chk("stall_count", fifo_count, 4);
    wb_we = 0;
    step();
    chk("drain_we", rf_we, 1);
    chk("drain_addr", rf_waddr, 2);
    chk("drain_data", rf_wdata, 32'hA0);
    chk("drain_stall_clear", wb_stall, 0);
    chk("drain_count", fifo_count, 3);
`ifdef RF_ARB_STATS_EN
    chk("stat_aux_writes", stat_aux_writes, 5);
    chk("stat_stall_cycles", stat_stall_cycles, 2);
`endif
    wb_we = 1;
    for (int k = 0; k < 8; k++) step();
    chk("age_cleared", wb_stall, 0);
    chk("pre_reset_count", fifo_count, 3);
    wb_we = 0;
    #2 reset = 1;
    #1;
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_we", rf_we, 0);
    chk("mid_rst_stall", wb_stall, 0);
    chk("mid_rst_busy", busy_mask, 0);
    step();
    reset = 0;
    step();
    chk("post_rst_count", fifo_count, 0);
    chk("post_rst_we", rf_we, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the register file's single write port between two requesters: the pipeline writeback stage (wb_*) and an auxiliary producer such as a multi-cycle mul/div unit or a debug loader (aux_*).
- Writeback has fixed priority. Auxiliary writes are buffered in a small FIFO and drained into idle writeback slots.
- A starvation counter forces a writeback bubble when the aux head waits too long.
- Exports a pending-write mask so hazard logic can stall reads of registers with queued aux writes.

Parameters:
DEPTH, 4, aux FIFO entries; power of 2, minimum 2
STARVE_LIMIT, 8, consecutive blocked cycles of a non-empty aux FIFO before wb_stall asserts

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
wb_we  in  1  writeback write request (always accepted)
wb_addr  in  5  writeback destination register
wb_data  in  32  writeback data
aux_valid  in  1  aux write request
aux_ready  out  1  FIFO can accept; equals (count != DEPTH)
aux_addr  in  5  aux destination register
aux_data  in  32  aux data
rf_we  out  1  registered write enable to the register file
rf_waddr  out  5  registered write address
rf_wdata  out  32  registered write data
wb_stall  out  1  registered; requests the pipeline to hold wb_we low for one cycle
busy_mask  out  32  bit n = 1 while a live aux write to register n is queued or in the output register
fifo_count  out  $clog2(DEPTH)+1  live plus dead entries in the FIFO

Behaviour:
- Reset values (asynchronous): rf_we=0, rf_waddr=0, rf_wdata=0, wb_stall=0, FIFO empty, age counter=0, busy_mask=0.
- Aux accept: when aux_valid && aux_ready, the entry is pushed. aux_addr==0 is handshaken but discarded, with no push.
- aux_ready depends on count only. When full, aux_ready=0 even if a pop occurs in the same cycle.
- Issue decision is made each cycle from the current inputs and FIFO head. The result is registered onto rf_* at the next edge, so latency is 1 cycle.
  - wb_we=1 and wb_addr!=0: rf_we=1 with wb_addr/wb_data. The FIFO head is not popped.
  - wb_we=1 and wb_addr==0: treated as an idle slot; the aux head may issue.
  - Slot idle and FIFO non-empty: pop the head. If the head is live, rf_we=1 with its addr/data. If dead, rf_we=0.
  - Otherwise rf_we=0; rf_waddr/rf_wdata hold their previous values.
- Ordering and kill rule: aux entries are older in program order than any concurrent writeback.
  - An accepted wb write to address A marks every queued entry with addr A dead, including an entry pushed to A in the same cycle.
  - Dead entries still occupy a slot and still drain one per idle slot.
- busy_mask is recomputed from live entries plus the output register when it holds an aux-sourced write.
- Starvation:
  - age increments each cycle the FIFO is non-empty and the head is blocked by wb.
  - age clears on any pop or when the FIFO is empty, and saturates at STARVE_LIMIT.
  - wb_stall=1 on the cycle after age reaches STARVE_LIMIT, held until the head pops.
  - If wb_we is still asserted during wb_stall, wb still wins (no data loss) and wb_stall stays high.
- Simultaneous push and pop when non-full: both occur and count is unchanged. Push on empty plus idle slot: the entry issues the next cycle at the earliest, so push-to-rf_we is 2 cycles.
- FIFO pointers wrap modulo DEPTH.
- Reset mid-operation flushes all queued entries; queued aux writes are lost.

Optional Feature:
- Macro: RF_ARB_STATS_EN.
- Defined: adds two outputs, 16-bit each, cleared by reset and saturating at 16'hFFFF:
  - stat_aux_writes: counts live aux writes issued to rf.
  - stat_stall_cycles: counts cycles with wb_stall=1.
- Not defined: ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then wb_we=1, wb_addr=5, wb_data=32'h1234 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=32'h1234; busy_mask=0.
- wb idle; push aux addr=7 data=32'h400 -> rf_we=1, waddr=7 two cycles after the push; busy_mask[7]=1 until that write leaves the output register.
- Push 4 aux entries with wb_we held high -> aux_ready=0, fifo_count=4. After 8 blocked cycles wb_stall=1. Drop wb_we for one cycle -> head issues, wb_stall returns to 0, age clears.
- Queue aux to register 9, then wb write to register 9 with data 32'hAA before the drain -> entry killed; the drain cycle shows rf_we=0; final r9=32'hAA; busy_mask[9]=0 immediately after the kill.
- aux_addr=0 push and wb_addr=0 write -> fifo_count unchanged and rf_we never asserts. Assert reset with 3 entries queued -> fifo_count=0, rf_we=0, wb_stall=0.
- With RF_ARB_STATS_EN defined: 3 live aux issues plus 2 stall cycles -> stat_aux_writes=3, stat_stall_cycles=2.
